// File: rtl/fir_stream_ctrl_if.sv
// Handshake and filter-side signals of the fir stream sequencer.
// master: sources and filter model (bench side); slave: the sequencer.
interface fir_stream_ctrl_if #(
   parameter int DW = 8
);
   logic          coef_valid;
   logic [DW-1:0] coef_data;
   logic          coef_ready;
   logic          samp_valid;
   logic [DW-1:0] samp_data;
   logic          samp_ready;
   logic [DW-1:0] fir_data;
   logic          fir_sample_enable;
   logic          fir_coef_enable;
   logic          fir_error;
   logic          configured;
   logic          err;

   modport master (
      output coef_valid, coef_data, samp_valid, samp_data, fir_error,
      input  coef_ready, samp_ready, fir_data, fir_sample_enable,
             fir_coef_enable, configured, err
   );

   modport slave (
      input  coef_valid, coef_data, samp_valid, samp_data, fir_error,
      output coef_ready, samp_ready, fir_data, fir_sample_enable,
             fir_coef_enable, configured, err
   );
endinterface

// File: rtl/fir_stream_ctrl.sv
// Sequencer in front of the fir block: buffers a full coefficient set,
// replays it as N contiguous coef_enable beats, gates samples, and
// latches the filter error until reset.
//
// state | meaning
// IDLE  | not yet configured; filling the coefficient buffer, samples refused
// LOAD  | replaying buffered coefficients, idx 0..N-1 (beats lag by one cycle)
// GAP   | one quiet cycle after the burst; clears buffer, marks configured
// RUN   | samples flow; a new set may fill in the background
// ERR   | filter reported an error; everything frozen until reset
module fir_stream_ctrl #(
   parameter int N  = 5,
   parameter int DW = 8
) (
   input logic              clk,
   input logic              reset,
   fir_stream_ctrl_if.slave bus
);
   localparam int CW = $clog2(N + 1);
   localparam int IW = (N > 1) ? $clog2(N) : 1;

   typedef enum logic [2:0] {IDLE, LOAD, GAP, RUN, ERR} state_t;

   state_t        state, state_nxt;
   logic [CW-1:0] cnt, cnt_nxt;
   logic [IW-1:0] idx, idx_nxt;
   logic [DW-1:0] coef_buf [N];
   logic [DW-1:0] coef_sel;
   logic [DW-1:0] data_q, data_nxt;
   logic          fce_q, fce_nxt;
   logic          fse_q, fse_nxt;
   logic          cfg_q, cfg_nxt;
   logic          full;
   logic          coef_acc;
   logic          samp_acc;

   assign full = (cnt == CW'(N));

   // Readies are held low while reset is asserted so every output reads 0.
   assign bus.coef_ready = reset && !full && ((state == IDLE) || (state == RUN));
   assign bus.samp_ready = reset && (state == RUN) && !full && !bus.fir_error;

   assign coef_acc = bus.coef_valid && bus.coef_ready;
   assign samp_acc = bus.samp_valid && bus.samp_ready;

   assign bus.fir_data          = data_q;
   assign bus.fir_coef_enable   = fce_q;
   assign bus.fir_sample_enable = fse_q;
   assign bus.configured        = cfg_q;
   assign bus.err               = (state == ERR);

   // Select the buffered coefficient for the current burst index.
   always_comb begin
      coef_sel = '0;
      for (int i = 0; i < N; i++) begin
         if (idx == IW'(i)) coef_sel = coef_buf[i];
      end
   end

   // State register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= IDLE;
      else        state <= state_nxt;
   end

   // Next state, buffer count, burst index and next registered outputs.
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      idx_nxt   = idx;
      fce_nxt   = 1'b0;
      fse_nxt   = 1'b0;
      data_nxt  = data_q;
      cfg_nxt   = cfg_q;
      if (coef_acc) cnt_nxt = cnt + CW'(1);
      case (state)
         IDLE: begin
            if (full) begin
               state_nxt = LOAD;
               idx_nxt   = '0;
            end
         end
         RUN: begin
            if (samp_acc) begin
               fse_nxt  = 1'b1;
               data_nxt = bus.samp_data;
            end
            // Wait for the last sample beat to leave before starting a burst.
            if (full && !fse_q) begin
               state_nxt = LOAD;
               idx_nxt   = '0;
            end
         end
         LOAD: begin
            fce_nxt  = 1'b1;
            data_nxt = coef_sel;
            if (idx == IW'(N - 1)) state_nxt = GAP;
            else                   idx_nxt   = idx + IW'(1);
         end
         GAP: begin
            cnt_nxt   = '0;
            cfg_nxt   = 1'b1;
            state_nxt = RUN;
         end
         ERR: begin
         end
         default: state_nxt = IDLE;
      endcase
      // Error wins over everything, aborting any burst in progress.
      if (bus.fir_error) begin
         state_nxt = ERR;
         fce_nxt   = 1'b0;
         fse_nxt   = 1'b0;
         data_nxt  = data_q;
      end
   end

   // Datapath registers and registered filter-side outputs.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt    <= '0;
         idx    <= '0;
         data_q <= '0;
         fce_q  <= 1'b0;
         fse_q  <= 1'b0;
         cfg_q  <= 1'b0;
      end else begin
         cnt    <= cnt_nxt;
         idx    <= idx_nxt;
         data_q <= data_nxt;
         fce_q  <= fce_nxt;
         fse_q  <= fse_nxt;
         cfg_q  <= cfg_nxt;
      end
   end

   // Coefficient buffer write at the current fill position.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < N; i++) coef_buf[i] <= '0;
      end else begin
         for (int i = 0; i < N; i++) begin
            if (coef_acc && (cnt == CW'(i))) coef_buf[i] <= bus.coef_data;
         end
      end
   end
endmodule

// File: tb/tb_fir_stream_ctrl.sv
// Randomized bench for fir_stream_ctrl with a queue-based reference model.
module tb_fir_stream_ctrl;
   localparam int N  = 5;
   localparam int DW = 8;

   logic clk   = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   fir_stream_ctrl_if #(.DW(DW)) bus ();
   fir_stream_ctrl #(.N(N), .DW(DW)) dut (.clk(clk), .reset(reset), .bus(bus));

   int errors = 0;
   int checks = 0;
   int cyc    = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   logic [DW-1:0] mq[$];
   bit            m_burst = 0;
   int            m_pos   = 0;
   bit            m_err = 0, m_cfg = 0, m_fce = 0, m_fse = 0;
   logic [DW-1:0] m_data = '0;

   function automatic bit m_cready();
      return reset && !m_err && !m_burst && (mq.size() < N);
   endfunction
   function automatic bit m_sready();
      return reset && !m_err && !m_burst && m_cfg && (mq.size() < N) && !bus.fir_error;
   endfunction

   initial begin
      bit ca, sa, n_fce, n_fse;
      logic [DW-1:0] n_data;
      forever begin
         @(posedge clk or negedge reset);
         if (!reset) begin
            mq.delete(); m_burst = 0; m_pos = 0;
            m_err = 0; m_cfg = 0; m_fce = 0; m_fse = 0; m_data = '0;
         end else begin
            ca = bus.coef_valid && m_cready();
            sa = bus.samp_valid && m_sready();
            n_fce = 0; n_fse = 0; n_data = m_data;
            if (!m_err) begin
               if (bus.fir_error) begin
                  m_err = 1; m_burst = 0;
               end else begin
                  if (m_burst) begin
                     if (m_pos < N) begin
                        n_fce = 1; n_data = mq[m_pos]; m_pos++;
                     end else begin
                        m_burst = 0; mq.delete(); m_cfg = 1;
                     end
                  end else if (mq.size() == N && !m_fse) begin
                     m_burst = 1; m_pos = 0;
                  end
                  if (sa) begin n_fse = 1; n_data = bus.samp_data; end
                  if (ca) mq.push_back(bus.coef_data);
               end
            end
            m_fce = n_fce; m_fse = n_fse; m_data = n_data;
         end
      end
   end

   // ---------------- beat logs and per-cycle compare ----------------
   int            cl_cyc[$], sl_cyc[$];
   logic [DW-1:0] cl_dat[$], sl_dat[$];

   initial begin
      int run = 0;
      forever begin
         @(negedge clk);
         cyc++;
         chk("coef_ready", bus.coef_ready, m_cready());
         chk("samp_ready", bus.samp_ready, m_sready());
         chk("fir_data", bus.fir_data, m_data);
         chk("fir_coef_enable", bus.fir_coef_enable, m_fce);
         chk("fir_sample_enable", bus.fir_sample_enable, m_fse);
         chk("configured", bus.configured, m_cfg);
         chk("err", bus.err, m_err);
         chk("no_overlap", bus.fir_coef_enable && bus.fir_sample_enable, 0);
         if (!bus.configured) chk("no_samp_unconfigured", bus.fir_sample_enable, 0);
         if (!reset) run = 0;
         else if (bus.fir_coef_enable) run++;
         else if (run > 0) begin
            if (!bus.err) chk("coef_run_len", run, N);
            run = 0;
         end
         if (bus.fir_coef_enable)   begin cl_cyc.push_back(cyc); cl_dat.push_back(bus.fir_data); end
         if (bus.fir_sample_enable) begin sl_cyc.push_back(cyc); sl_dat.push_back(bus.fir_data); end
      end
   end

   // ---------------- source driver ----------------
   logic [DW-1:0] cq[$], sq[$];
   int            c_mode = 0;   // 0: toggle every other cycle, else percent valid
   int            s_pct  = 100;

   initial begin
      bit acc_c, acc_s, hold_c, hold_s;
      bus.coef_valid = 0; bus.coef_data = '0;
      bus.samp_valid = 0; bus.samp_data = '0;
      forever begin
         @(negedge clk);
         acc_c = bus.coef_valid && bus.coef_ready;
         acc_s = bus.samp_valid && bus.samp_ready;
         @(posedge clk);
         #1;
         if (acc_c && cq.size() > 0) void'(cq.pop_front());
         if (acc_s && sq.size() > 0) void'(sq.pop_front());
         hold_c = bus.coef_valid && !acc_c;
         hold_s = bus.samp_valid && !acc_s;
         if (cq.size() == 0) bus.coef_valid = 0;
         else if (!hold_c) bus.coef_valid = (c_mode == 0) ? !bus.coef_valid
                                                          : ($urandom_range(99) < c_mode);
         if (cq.size() > 0) bus.coef_data = cq[0];
         if (sq.size() == 0) bus.samp_valid = 0;
         else if (!hold_s) bus.samp_valid = ($urandom_range(99) < s_pct);
         if (sq.size() > 0) bus.samp_data = sq[0];
      end
   end

   // ---------------- helpers ----------------
   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #2;
   endtask

   task automatic clear_logs();
      cl_cyc.delete(); cl_dat.delete(); sl_cyc.delete(); sl_dat.delete();
   endtask

   task automatic wait_drain(input string nm, input int budget);
      int k = 0;
      while ((cq.size() != 0 || sq.size() != 0) && k < budget) begin
         @(posedge clk); k++;
      end
      chk({nm, "_drain_timeout"}, (k < budget), 1);
      step(8);
   endtask

   task automatic chk_burst(input string nm, input int v [N]);
      chk({nm, "_beats"}, cl_dat.size(), N);
      for (int i = 0; i < N && i < cl_dat.size(); i++) begin
         chk({nm, "_beat_data"}, cl_dat[i], v[i]);
         chk({nm, "_beat_contig"}, cl_cyc[i], cl_cyc[0] + i);
      end
   endtask

   task automatic push_rand_coefs();
      for (int i = 0; i < N; i++) cq.push_back(DW'($urandom_range(255)));
   endtask

   task automatic push_rand_samps(input int n);
      for (int i = 0; i < n; i++) sq.push_back(DW'($urandom_range(255)));
   endtask

   task automatic do_reset();
      reset = 0;
      step(1);
      cq.delete(); sq.delete(); clear_logs();
      bus.fir_error = 0;
      step(2);
      reset = 1;
      step(1);
   endtask

   // ---------------- main sequence ----------------
   initial begin
      int v1 [N] = '{1, 2, 3, 4, 5};
      int v2 [N] = '{9, 8, 7, 6, 5};
      int fc, ls, fs, seen, k;
      bus.fir_error = 0;
      #1 reset = 0;
      step(3);
      chk("rst_coef_ready", bus.coef_ready, 0);
      chk("rst_samp_ready", bus.samp_ready, 0);
      chk("rst_fir_data", bus.fir_data, 0);
      chk("rst_coef_en", bus.fir_coef_enable, 0);
      chk("rst_samp_en", bus.fir_sample_enable, 0);
      chk("rst_configured", bus.configured, 0);
      chk("rst_err", bus.err, 0);
      reset = 1;
      step(1);

      // Samples offered early; coefficients 1..5 with valid toggling.
      clear_logs();
      c_mode = 0; s_pct = 100;
      for (int i = 0; i < N; i++) cq.push_back(DW'(v1[i]));
      sq.push_back(8'd10); sq.push_back(8'd20); sq.push_back(8'd30);
      wait_drain("cfg1", 200);
      chk_burst("cfg1", v1);
      chk("cfg1_samp_count", sl_dat.size(), 3);
      if (sl_dat.size() == 3 && cl_cyc.size() == N) begin
         chk("samp10", sl_dat[0], 10);
         chk("samp20", sl_dat[1], 20);
         chk("samp30", sl_dat[2], 30);
         chk("samp_contig", sl_cyc[2] - sl_cyc[0], 2);
         chk("gap_after_burst", sl_cyc[0] - cl_cyc[N-1], 2);
      end
      chk("cfg1_configured", bus.configured, 1);
      chk("cfg1_err", bus.err, 0);

      // Continuous samples while 9..5 is buffered in the background.
      clear_logs();
      s_pct = 100;
      push_rand_samps(60);
      step(3);
      c_mode = 50;
      for (int i = 0; i < N; i++) cq.push_back(DW'(v2[i]));
      wait_drain("cfg2", 400);
      chk_burst("cfg2", v2);
      if (cl_cyc.size() == N) begin
         fc = cl_cyc[0]; ls = -1000; fs = 100000;
         foreach (sl_cyc[i]) begin
            if (sl_cyc[i] < fc && sl_cyc[i] > ls) ls = sl_cyc[i];
            if (sl_cyc[i] > fc && sl_cyc[i] < fs) fs = sl_cyc[i];
         end
         chk("pre_burst_gap", fc - ls, 3);
         chk("post_burst_gap", fs - cl_cyc[N-1], 2);
      end

      // Random reconfiguration rounds.
      for (int r = 0; r < 6; r++) begin
         c_mode = $urandom_range(90, 20);
         s_pct  = $urandom_range(100, 30);
         push_rand_coefs();
         push_rand_samps($urandom_range(40, 5));
         wait_drain("rand", 1500);
      end

      // Filter error during RUN: sticky freeze.
      s_pct = 100;
      push_rand_samps(20);
      step(4);
      bus.fir_error = 1;
      step(1);
      chk("err_next_cycle", bus.err, 1);
      chk("err_coef_ready", bus.coef_ready, 0);
      chk("err_samp_ready", bus.samp_ready, 0);
      chk("err_samp_en", bus.fir_sample_enable, 0);
      bus.fir_error = 0;
      push_rand_coefs();
      step(20);
      chk("err_sticky", bus.err, 1);
      chk("err_sticky_cready", bus.coef_ready, 0);
      chk("err_sticky_sready", bus.samp_ready, 0);
      chk("err_sticky_cen", bus.fir_coef_enable, 0);
      do_reset();
      chk("err_cleared", bus.err, 0);

      // Configure, then reset on the 3rd beat of a reconfiguration burst.
      c_mode = 100; s_pct = 100;
      push_rand_coefs();
      push_rand_samps(4);
      wait_drain("cfg3", 300);
      chk("cfg3_configured", bus.configured, 1);
      push_rand_coefs();
      seen = 0; k = 0;
      while (seen < 3 && k < 200) begin
         @(negedge clk); k++;
         if (bus.fir_coef_enable) seen++;
      end
      chk("third_beat_seen", seen, 3);
      #2 reset = 0;
      #1;
      chk("midrst_coef_en", bus.fir_coef_enable, 0);
      chk("midrst_fir_data", bus.fir_data, 0);
      chk("midrst_configured", bus.configured, 0);
      chk("midrst_coef_ready", bus.coef_ready, 0);
      step(1);
      cq.delete(); sq.delete();
      step(2);
      reset = 1;
      step(1);
      clear_logs();
      sq.push_back(8'd55); sq.push_back(8'd66);
      step(10);
      chk("post_rst_no_samples", sl_dat.size(), 0);
      chk("post_rst_samp_ready", bus.samp_ready, 0);
      push_rand_coefs();
      wait_drain("cfg4", 300);
      chk("cfg4_samp_count", sl_dat.size(), 2);
      if (sl_dat.size() == 2) begin
         chk("cfg4_samp55", sl_dat[0], 55);
         chk("cfg4_samp66", sl_dat[1], 66);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation exceeded time limit, errors=%0d checks=%0d", errors, checks);
      $fatal(1, "watchdog");
   end
endmodule
